// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply (Booth radix-2) and restoring divide, one bit per cycle.
// Drives a single Hi/Lo write pulse on completion and flags divide-by-zero.
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero,
   output logic                  hilo_write,
   output logic [DATA_WIDTH-1:0] hi_result,
   output logic [DATA_WIDTH-1:0] lo_result
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH, DZERO} state_t;

   state_t          state_q, state_d;
   logic            op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    mcand_q, mcand_d;     // multiplicand, or |divisor|
   logic [W:0]      acc_q, acc_d;         // Booth accumulator, or remainder
   logic [W-1:0]    mplier_q, mplier_d;   // multiplier, or dividend/quotient
   logic            qm1_q, qm1_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;

   logic [W:0]      mcand_ext, booth_sum, shifted, diff, step_acc;
   logic [W-1:0]    step_low, a_mag, b_mag;
   logic            step_qm1;

   // One iteration of whichever datapath is active.
   always_comb begin
      mcand_ext = {mcand_q[W-1], mcand_q};
      booth_sum = acc_q;
      shifted   = {acc_q[W-1:0], mplier_q[W-1]};
      diff      = shifted - {1'b0, mcand_q};
      step_acc  = acc_q;
      step_low  = mplier_q;
      step_qm1  = qm1_q;
      if (!op_q) begin
         case ({mplier_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
         endcase
         step_acc = {booth_sum[W], booth_sum[W:1]};
         step_low = {booth_sum[0], mplier_q[W-1:1]};
         step_qm1 = mplier_q[0];
      end else if (!diff[W]) begin
         step_acc = {1'b0, diff[W-1:0]};
         step_low = {mplier_q[W-2:0], 1'b1};
      end else begin
         step_acc = {1'b0, shifted[W-1:0]};
         step_low = {mplier_q[W-2:0], 1'b0};
      end
   end

   always_comb begin
      a_mag    = operand_a[W-1] ? -operand_a : operand_a;
      b_mag    = operand_b[W-1] ? -operand_b : operand_b;
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      qm1_d    = qm1_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               cnt_d = CNT_INIT;
               acc_d = '0;
               qm1_d = 1'b0;
               if (op) begin
                  mcand_d  = b_mag;
                  mplier_d = a_mag;
                  qneg_d   = operand_a[W-1] ^ operand_b[W-1];
                  rneg_d   = operand_a[W-1];
                  state_d  = (operand_b == '0) ? DZERO : RUN;
               end else begin
                  mcand_d  = operand_a;
                  mplier_d = operand_b;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            acc_d    = step_acc;
            mplier_d = step_low;
            qm1_d    = step_qm1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = FINISH;
               // Divide sign fix lands directly in the result registers.
               if (op_q) begin
                  hi_d = rneg_q ? -step_acc[W-1:0] : step_acc[W-1:0];
                  lo_d = qneg_q ? -step_low : step_low;
               end else begin
                  hi_d = step_acc[W-1:0];
                  lo_d = step_low;
               end
            end
         end
         FINISH:  state_d = IDLE;
         DZERO:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         qm1_q    <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         qm1_q    <= qm1_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FINISH) || (state_q == DZERO);
   assign div_zero   = (state_q == DZERO);
   assign hilo_write = (state_q == FINISH);
   assign hi_result  = hi_q;
   assign lo_result  = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, divide-by-zero,
// ignored start while busy, and reset abort.
module tb_muldiv_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        hilo_write;
   logic [31:0] hi_result;
   logic [31:0] lo_result;

   int checks   = 0;
   int failures = 0;

   muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hilo_write (hilo_write),
      .hi_result  (hi_result),
      .lo_result  (lo_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request and steps until done (or abort/timeout); returns
   // sampled at the done cycle. poke_cyc injects a start while busy,
   // rst_cyc asserts reset for one edge at that cycle.
   task automatic run_op(input logic opv, input logic [31:0] a, input logic [31:0] b,
                         input int poke_cyc, input int rst_cyc,
                         output int lat, output int busy_cnt, output int hw_cnt,
                         output int dz_cnt);
      op = opv; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0; hw_cnt = 0; dz_cnt = 0;
      for (int c = 1; c <= 60; c++) begin
         if (busy) busy_cnt++;
         if (hilo_write) hw_cnt++;
         if (div_zero) dz_cnt++;
         if (done) begin
            lat = c;
            break;
         end
         if (c == poke_cyc) begin
            start = 1'b1; op = ~opv; operand_a = 32'h64; operand_b = 32'h7;
         end else begin
            start = 1'b0;
         end
         if (c == rst_cyc) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      $display("op=%0d a=0x%08h b=0x%08h lat=%0d hi=0x%08h lo=0x%08h", opv, a, b, lat, hi_result, lo_result);
   endtask

   task automatic step_idle_check(input string tag);
      @(posedge clk); #1;
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_done"}, done, 0);
   endtask

   typedef struct {
      logic        opv;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int lat, bc, hw, dz, extra_done;
      reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_divz", div_zero, 0);
      check("rst_hw", hilo_write, 0);
      check("rst_hi", hi_result, 0);
      check("rst_lo", lo_result, 0);

      vecs[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].opv, vecs[i].a, vecs[i].b, 0, 0, lat, bc, hw, dz);
         check($sformatf("v%0d_lat", i), lat, 33);
         check($sformatf("v%0d_busy_cycles", i), bc, 33);
         check($sformatf("v%0d_hw", i), hw, 1);
         check($sformatf("v%0d_divz", i), dz, 0);
         check($sformatf("v%0d_hi", i), hi_result, vecs[i].hi);
         check($sformatf("v%0d_lo", i), lo_result, vecs[i].lo);
         step_idle_check($sformatf("v%0d", i));
         check($sformatf("v%0d_hold_lo", i), lo_result, vecs[i].lo);
      end

      // Prime Hi=0x11, Lo=0x22 via 0x451 / 0x20, then divide by zero.
      run_op(1'b1, 32'h451, 32'h20, 0, 0, lat, bc, hw, dz);
      check("prime_hi", hi_result, 32'h11);
      check("prime_lo", lo_result, 32'h22);
      step_idle_check("prime");
      run_op(1'b1, 32'd100, 32'd0, 0, 0, lat, bc, hw, dz);
      check("dz_lat", lat, 1);
      check("dz_flag", dz, 1);
      check("dz_hw", hw, 0);
      check("dz_hwnow", hilo_write, 0);
      check("dz_hi", hi_result, 32'h11);
      check("dz_lo", lo_result, 32'h22);
      step_idle_check("dz");

      // start while busy is ignored; operands changed mid-run have no effect.
      run_op(1'b0, 32'd3, 32'd5, 10, 0, lat, bc, hw, dz);
      check("ign_lat", lat, 33);
      check("ign_hi", hi_result, 0);
      check("ign_lo", lo_result, 15);
      extra_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      check("ign_single_done", extra_done, 0);
      check("ign_idle", busy, 0);

      // Reset mid-divide aborts without a write.
      run_op(1'b1, 32'd1000, 32'd7, 0, 12, lat, bc, hw, dz);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_hw", hilo_write, 0);
      check("abort_hi", hi_result, 0);
      check("abort_lo", lo_result, 0);
      hw = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (hilo_write) hw++;
      end
      check("abort_no_write", hw, 0);
      run_op(1'b0, 32'd2, 32'd2, 0, 0, lat, bc, hw, dz);
      check("post_lat", lat, 33);
      check("post_hi", hi_result, 0);
      check("post_lo", lo_result, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
